// File: rtl/collatz_pkg.sv
// Shared state encoding, default widths and the 3n+1 helper for the Collatz sweep controller.
package collatz_pkg;

    localparam int unsigned ODefault = 14;
    localparam int unsigned CDefault = 8;
    localparam int unsigned OMax     = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStep,
        StCheck,
        StFinish
    } state_e;

    // Two guard bits above the operand let callers detect overflow of an O-bit value.
    function automatic logic [OMax+1:0] odd_next(input logic [OMax-1:0] value);
        logic [OMax+1:0] v;
        v = {2'b00, value};
        return (v << 1) + v + {{(OMax + 1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/collatz_sweep_ctrl_if.sv
// Control/status bundle between the sweep controller and its host.
// COLLATZ_PEAK_EN adds the peak trajectory value of the best start.
interface collatz_sweep_ctrl_if
    import collatz_pkg::*;
#(
    parameter int unsigned O = ODefault,
    parameter int unsigned C = CDefault
);
    logic         en;
    logic         start;
    logic         abort;
    logic [O-1:0] first;
    logic [O-1:0] last;
    logic         busy;
    logic         done;
    logic [O-1:0] cur_start;
    logic [C-1:0] cur_steps;
    logic [O-1:0] best_start;
    logic [C-1:0] best_steps;
    logic         ovf;
`ifdef COLLATZ_PEAK_EN
    logic [O-1:0] peak;

    modport master (
        output en, start, abort, first, last,
        input  busy, done, cur_start, cur_steps, best_start, best_steps, ovf, peak
    );
    modport slave (
        input  en, start, abort, first, last,
        output busy, done, cur_start, cur_steps, best_start, best_steps, ovf, peak
    );
`else
    modport master (
        output en, start, abort, first, last,
        input  busy, done, cur_start, cur_steps, best_start, best_steps, ovf
    );
    modport slave (
        input  en, start, abort, first, last,
        output busy, done, cur_start, cur_steps, best_start, best_steps, ovf
    );
`endif
endinterface

// File: rtl/collatz_stepper.sv
// Collatz trajectory datapath: current value, saturating step count and (COLLATZ_PEAK_EN) run peak.
module collatz_stepper
    import collatz_pkg::*;
#(
    parameter int unsigned O = ODefault,
    parameter int unsigned C = CDefault
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [O-1:0] init_i,
    output logic         value_is_one_o,
    output logic         ovf_pulse_o,
    output logic [C-1:0] steps_o
`ifdef COLLATZ_PEAK_EN
    ,
    output logic [O-1:0] run_peak_o
`endif
);
    logic [O-1:0]    value_q, value_d, next_val;
    logic [C-1:0]    steps_q, steps_d;
    logic [OMax+1:0] tri_wide;
    logic            advance;
`ifdef COLLATZ_PEAK_EN
    logic [O-1:0]    run_peak_q, run_peak_d;
`endif

    assign tri_wide       = odd_next(OMax'(value_q));
    assign value_is_one_o = (value_q == O'(1));
    assign ovf_pulse_o    = step_i & ~value_is_one_o & value_q[0] & (|tri_wide[OMax+1:O]);
    assign advance        = step_i & ~value_is_one_o & ~ovf_pulse_o;
    assign next_val       = value_q[0] ? tri_wide[O-1:0] : (value_q >> 1);
    assign steps_o        = steps_q;

    always_comb begin
        value_d = value_q;
        steps_d = steps_q;
`ifdef COLLATZ_PEAK_EN
        run_peak_d = run_peak_q;
`endif
        if (clr_i) begin
            steps_d = '0;
        end
        if (load_i) begin
            value_d = init_i;
            steps_d = '0;
`ifdef COLLATZ_PEAK_EN
            run_peak_d = init_i;
`endif
        end else if (advance) begin
            value_d = next_val;
            steps_d = (&steps_q) ? steps_q : steps_q + C'(1);
`ifdef COLLATZ_PEAK_EN
            run_peak_d = (next_val > run_peak_q) ? next_val : run_peak_q;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
            steps_q <= '0;
`ifdef COLLATZ_PEAK_EN
            run_peak_q <= '0;
`endif
        end else begin
            value_q <= value_d;
            steps_q <= steps_d;
`ifdef COLLATZ_PEAK_EN
            run_peak_q <= run_peak_d;
`endif
        end
    end

`ifdef COLLATZ_PEAK_EN
    assign run_peak_o = run_peak_q;
`endif

endmodule

// File: rtl/collatz_sweep_ctrl.sv
// Sweeps Collatz start values [first..last] and tracks the start with the most steps.
// COLLATZ_PEAK_EN adds a peak output for the best start's trajectory.
module collatz_sweep_ctrl
    import collatz_pkg::*;
#(
    parameter int unsigned O = ODefault,
    parameter int unsigned C = CDefault
) (
    input logic                clk,
    input logic                arst_n,
    collatz_sweep_ctrl_if.slave bus
);
    state_e       state_q, state_d;
    logic [O-1:0] last_q, last_d;
    logic [O-1:0] cur_start_q, cur_start_d;
    logic [O-1:0] best_start_q, best_start_d;
    logic [C-1:0] best_steps_q, best_steps_d;
    logic         ovf_q, ovf_d;
    logic         invalid_q, invalid_d;
    logic         busy_q, done_q;
    logic [O-1:0] first_eff;
    logic [C-1:0] cur_steps;
    logic         st_clr, st_load, st_step, value_is_one, ovf_pulse;
`ifdef COLLATZ_PEAK_EN
    logic [O-1:0] peak_q, peak_d, run_peak;
`endif

    collatz_stepper #(
        .O(O),
        .C(C)
    ) u_stepper (
        .clk_i          (clk),
        .rst_ni         (arst_n),
        .clr_i          (st_clr),
        .load_i         (st_load),
        .step_i         (st_step),
        .init_i         (cur_start_q),
        .value_is_one_o (value_is_one),
        .ovf_pulse_o    (ovf_pulse),
        .steps_o        (cur_steps)
`ifdef COLLATZ_PEAK_EN
        ,
        .run_peak_o     (run_peak)
`endif
    );

    assign first_eff = (bus.first == '0) ? O'(1) : bus.first;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        cur_start_d  = cur_start_q;
        best_start_d = best_start_q;
        best_steps_d = best_steps_q;
        ovf_d        = ovf_q;
        invalid_d    = invalid_q;
        st_clr       = 1'b0;
        st_load      = 1'b0;
        st_step      = 1'b0;
`ifdef COLLATZ_PEAK_EN
        peak_d = peak_q;
`endif
        // Abort wins over every other transition and freezes partial results.
        if (state_q != StIdle && bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        last_d       = bus.last;
                        cur_start_d  = first_eff;
                        best_start_d = '0;
                        best_steps_d = '0;
                        ovf_d        = 1'b0;
                        st_clr       = 1'b1;
`ifdef COLLATZ_PEAK_EN
                        peak_d = '0;
`endif
                        state_d = (first_eff > bus.last) ? StFinish : StLoad;
                    end
                end
                StLoad: begin
                    st_load   = 1'b1;
                    invalid_d = 1'b0;
                    state_d   = StStep;
                end
                StStep: begin
                    if (bus.en) begin
                        st_step = 1'b1;
                        if (value_is_one) begin
                            state_d = StCheck;
                        end else if (ovf_pulse) begin
                            ovf_d     = 1'b1;
                            invalid_d = 1'b1;
                            state_d   = StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (!invalid_q && cur_steps > best_steps_q) begin
                        best_start_d = cur_start_q;
                        best_steps_d = cur_steps;
`ifdef COLLATZ_PEAK_EN
                        peak_d = run_peak;
`endif
                    end
                    // Compare before incrementing so cur_start cannot wrap at the top of range.
                    if (cur_start_q == last_q) begin
                        state_d = StFinish;
                    end else begin
                        cur_start_d = cur_start_q + O'(1);
                        state_d     = StLoad;
                    end
                end
                StFinish: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= StIdle;
            last_q       <= '0;
            cur_start_q  <= '0;
            best_start_q <= '0;
            best_steps_q <= '0;
            ovf_q        <= 1'b0;
            invalid_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef COLLATZ_PEAK_EN
            peak_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cur_start_q  <= cur_start_d;
            best_start_q <= best_start_d;
            best_steps_q <= best_steps_d;
            ovf_q        <= ovf_d;
            invalid_q    <= invalid_d;
            busy_q       <= (state_d != StIdle);
            done_q       <= (state_d == StFinish);
`ifdef COLLATZ_PEAK_EN
            peak_q <= peak_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cur_start  = cur_start_q;
    assign bus.cur_steps  = cur_steps;
    assign bus.best_start = best_start_q;
    assign bus.best_steps = best_steps_q;
    assign bus.ovf        = ovf_q;
`ifdef COLLATZ_PEAK_EN
    assign bus.peak = peak_q;
`endif

endmodule
